// File: rtl/wb_dest_pipe_if.sv
// wb_dest_pipe_if: destination-select inputs and write-back/hazard outputs of wb_dest_pipe
interface wb_dest_pipe_if #(parameter int ADDR_W = 5);
  logic [2:0]        reg_dest;
  logic [ADDR_W-1:0] instr_rt;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs;
  logic              issue;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] query_addr;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_valid;
  logic              busy;
  logic              hazard;
  logic              sel_err;
  modport master (
    output reg_dest, instr_rt, instr_rd, instr_rs, issue, stall, flush, query_addr,
    input  wb_addr, wb_valid, busy, hazard, sel_err
  );
  modport slave (
    input  reg_dest, instr_rt, instr_rd, instr_rs, issue, stall, flush, query_addr,
    output wb_addr, wb_valid, busy, hazard, sel_err
  );
endinterface

// File: rtl/wb_dest_pipe.sv
// wb_dest_pipe: selects the write-back register index and carries it with a valid bit
// through a DEPTH-stage shift pipe, with stall, flush and an in-flight hazard query.
module wb_dest_pipe #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int RA_IDX = 31,
  parameter int SP_IDX = 29
) (
  input logic         clk,
  input logic         reset,
  wb_dest_pipe_if.slave bus
);
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic                         sel_err_q, sel_err_d;
  logic [ADDR_W-1:0]            sel_addr;
  logic                         legal;
  logic                         hit;
  always_comb begin
    sel_addr = bus.reg_dest == 3'd0 ? bus.instr_rt :
               bus.reg_dest == 3'd1 ? bus.instr_rd :
               bus.reg_dest == 3'd2 ? ADDR_W'(RA_IDX) :
               bus.reg_dest == 3'd3 ? ADDR_W'(SP_IDX) :
               bus.reg_dest == 3'd4 ? bus.instr_rs : '0;
    legal = bus.reg_dest <= 3'd4;
  end
  // flush wins over stall; sel_err ignores flush so a flushed illegal issue is still reported
  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    sel_err_d = bus.issue && !bus.stall && !legal;
    if (bus.flush) begin
      valid_d = '0;
    end else if (!bus.stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        addr_d[i]  = addr_q[i-1];
      end
      valid_d[0] = bus.issue && legal && sel_addr != '0;
      addr_d[0]  = sel_addr;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      addr_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      sel_err_q <= sel_err_d;
    end
  end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      hit = hit | (valid_q[i] && addr_q[i] == bus.query_addr);
  end
  assign bus.wb_addr  = addr_q[DEPTH-1];
  assign bus.wb_valid = valid_q[DEPTH-1];
  assign bus.busy     = |valid_q;
  assign bus.hazard   = bus.query_addr != '0 && hit;
  assign bus.sel_err  = sel_err_q;
endmodule
